// File: rtl/lut_mac_sequencer_pkg.sv
// Shared constants and types for the LUT multiply-accumulate sequencer and
// the odd-multiple LUT constant multiplier it feeds.
package lut_mac_sequencer_pkg;

    localparam int A     = 32;  // fixed multiplier coefficient
    localparam int L     = 5;   // operand width (multiplier X bus)
    localparam int P_W   = 11;  // multiplier product width
    localparam int ACC_W = 14;  // accumulator / result width
    localparam int CNT_W = 5;   // sample counter width

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Observable internals of the sequencer pipeline.
    typedef struct packed {
        state_t state;
        logic   pend;
        logic   pend_last;
    } dbg_t;

endpackage

// File: rtl/lut_mac_sequencer_if.sv
// Bus bundle for the sequencer: sample input, multiplier side-band and
// frame result output.
interface lut_mac_sequencer_if;
    import lut_mac_sequencer_pkg::*;

    // Both handshakes: a transfer happens on a rising clk edge where valid
    // and ready are both high. A source holds valid and its payload stable
    // until that edge; ready may be asserted independently of valid.
    logic             in_valid;
    logic             in_ready;
    logic [L-1:0]     in_x;
    logic             in_last;

    logic [L-1:0]     mul_x;
    logic [P_W-1:0]   mul_product;

    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_x, in_last, mul_product, out_ready,
        output in_ready, mul_x, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output in_valid, in_x, in_last, mul_product, out_ready,
        input  in_ready, mul_x, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/lut_mac_sequencer_sat_accum.sv
// Saturating accumulator register: adds an unsigned addend when enabled,
// clamps at all-ones and raises a sticky saturation flag until cleared.
module sat_accum
    import lut_mac_sequencer_pkg::*;
#(
    parameter int W    = ACC_W,
    parameter int IN_W = P_W
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    input  logic [IN_W-1:0] addend,
    output logic [W-1:0]    sum,
    output logic            sat
);

    // One extra bit so the carry out marks a result above the W-bit range.
    logic [W:0] sum_ext;

    assign sum_ext = {1'b0, sum} + {{(W+1-IN_W){1'b0}}, addend};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum <= '0;
            sat <= 1'b0;
        end else if (en) begin
            if (sum_ext[W]) begin
                sum <= '1;
                sat <= 1'b1;
            end else begin
                sum <= sum_ext[W-1:0];
            end
        end
    end

endmodule

// File: rtl/lut_mac_sequencer.sv
// Streaming MAC front end: registers samples onto the LUT multiplier X bus,
// accumulates the returned products per frame and hands out the frame result.
module lut_mac_sequencer
    import lut_mac_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    lut_mac_sequencer_if.slave  bus,
    output dbg_t                dbg
);

    state_t           state_q;
    state_t           state_d;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             clear_frame;
    logic             accept;

    logic [L-1:0]     mul_x_q;
    logic             pend_q;
    logic             pend_last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_sat_q;
    logic [ACC_W-1:0] acc;
    logic             acc_sat;

    assign accept = bus.in_valid && in_ready_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        clear_frame = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready_c = 1'b1;
                if (accept && bus.in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            // The last sample's product is on mul_product this cycle.
            ST_DRAIN: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d     = ST_ACC;
                    clear_frame = 1'b1;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // pend marks that mul_x changed last cycle, so mul_product is valid now.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_x_q     <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else if (accept) begin
            mul_x_q     <= bus.in_x;
            pend_q      <= 1'b1;
            pend_last_q <= bus.in_last;
        end else begin
            pend_q      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_frame) begin
            cnt_q     <= '0;
            cnt_sat_q <= 1'b0;
        end else if (accept) begin
            if (cnt_q == CNT_MAX) begin
                cnt_sat_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    sat_accum #(
        .W    (ACC_W),
        .IN_W (P_W)
    ) u_sat_accum (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_frame),
        .en     (pend_q),
        .addend (bus.mul_product),
        .sum    (acc),
        .sat    (acc_sat)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.mul_x     = mul_x_q;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sum   = acc;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = acc_sat || cnt_sat_q;

    assign dbg.state     = state_q;
    assign dbg.pend      = pend_q;
    assign dbg.pend_last = pend_last_q;

endmodule

// File: tb/tb_lut_mac_sequencer.sv
// Bench for lut_mac_sequencer: directed frames from the test plan plus
// randomized frames, checked against a frame-level arithmetic model.
module tb_lut_mac_sequencer;
    import lut_mac_sequencer_pkg::*;

    localparam int RES_W   = 1 + CNT_W + ACC_W;
    localparam int SUM_LIM = (1 << ACC_W) - 1;
    localparam int CNT_LIM = (1 << CNT_W) - 1;

    typedef logic [L-1:0] x_q_t[$];

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lut_mac_sequencer_if bus();
    dbg_t dbg;

    lut_mac_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .dbg   (dbg)
    );

    // Behavioural stand-in for the LUT constant multiplier.
    assign bus.mul_product = P_W'(A * int'(bus.mul_x));

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [RES_W-1:0] exp_q[$];
    int   stall_pct = 0;
    bit   force_low = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame result from plain arithmetic: clamp the exact totals.
    function automatic logic [RES_W-1:0] model(input x_q_t xs);
        int sum = 0;
        int n   = xs.size();
        bit ovf;
        foreach (xs[i]) sum += A * int'(xs[i]);
        ovf = (sum > SUM_LIM) || (n > CNT_LIM);
        if (sum > SUM_LIM) sum = SUM_LIM;
        if (n > CNT_LIM) n = CNT_LIM;
        return {ovf, CNT_W'(n), ACC_W'(sum)};
    endfunction

    // ---------------- downstream sink ----------------
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (force_low) bus.out_ready = 1'b0;
            else           bus.out_ready = ($urandom_range(99) >= stall_pct);
        end
    end

    // ---------------- output monitor ----------------
    logic [RES_W-1:0] mon_exp;
    logic             held_valid = 1'b0;
    logic [ACC_W-1:0] held_sum;
    logic [CNT_W-1:0] held_cnt;
    logic             held_ovf;

    always @(negedge clk) begin
        if (reset) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("hold_out_valid", bus.out_valid, 1);
                check("hold_out_sum", bus.out_sum, held_sum);
                check("hold_out_count", bus.out_count, held_cnt);
                check("hold_out_ovf", bus.out_ovf, held_ovf);
            end
            if (bus.out_valid) begin
                check("in_ready_while_result", bus.in_ready, 0);
                if (bus.out_ready) begin
                    check("result_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_exp = exp_q.pop_front();
                        check("out_sum", bus.out_sum, mon_exp[ACC_W-1:0]);
                        check("out_count", bus.out_count, mon_exp[ACC_W +: CNT_W]);
                        check("out_ovf", bus.out_ovf, mon_exp[RES_W-1]);
                    end
                    held_valid = 1'b0;
                end else begin
                    held_valid = 1'b1;
                    held_sum   = bus.out_sum;
                    held_cnt   = bus.out_count;
                    held_ovf   = bus.out_ovf;
                end
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_sample(input logic [L-1:0] x, input bit last, output int waits);
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waits++;
            if (waits > 500) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("mul_x", bus.mul_x, x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input x_q_t xs, input bit push, input int max_gap);
        int w;
        if (push) exp_q.push_back(model(xs));
        foreach (xs[i]) begin
            idle($urandom_range(max_gap));
            drive_sample(xs[i], i == xs.size() - 1, w);
        end
    endtask

    task automatic wait_results();
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("results_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        x_q_t xs;
        int   w;
        int   b2b_x[6]   = '{3, 9, 31, 31, 31, 1};
        int   b2b_len[3] = '{2, 3, 1};
        int   k;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_count", bus.out_count, 0);
        check("rst_out_ovf", bus.out_ovf, 0);
        check("rst_mul_x", bus.mul_x, 0);
        check("rst_state", dbg.state, ST_ACC);
        @(posedge clk); #1;
        reset = 1'b0;
        stall_pct = 0;
        idle(1);

        // X=1,2,3 with latency and DRAIN observation.
        exp_q.push_back(model('{5'd1, 5'd2, 5'd3}));
        drive_sample(5'd1, 1'b0, w);
        drive_sample(5'd2, 1'b0, w);
        drive_sample(5'd3, 1'b1, w);
        @(negedge clk);
        check("lat_drain_out_valid", bus.out_valid, 0);
        check("lat_drain_state", dbg.state, ST_DRAIN);
        check("lat_drain_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("lat_hold_out_valid", bus.out_valid, 1);
        wait_results();

        // Single zero sample.
        send_frame('{5'd0}, 1'b1, 0);
        wait_results();

        // 17 x 31 saturates the sum.
        xs = {};
        repeat (17) xs.push_back(5'd31);
        send_frame(xs, 1'b1, 0);
        wait_results();

        // Held result with out_ready low for 5 cycles.
        force_low = 1'b1;
        idle(1);
        exp_q.push_back(model('{5'd16, 5'd5}));
        drive_sample(5'd16, 1'b0, w);
        drive_sample(5'd5, 1'b1, w);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_sum", bus.out_sum, 672);
            check("stall_in_ready", bus.in_ready, 0);
        end
        force_low = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", bus.in_ready, 1);
        check("release_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        send_frame('{5'd31}, 1'b1, 0);
        wait_results();

        // Reset in the middle of a 4-sample frame discards it.
        drive_sample(5'd9, 1'b0, w);
        drive_sample(5'd12, 1'b0, w);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_state", dbg.state, ST_ACC);
        check("midrst_out_sum", bus.out_sum, 0);
        check("midrst_out_count", bus.out_count, 0);
        check("midrst_pend", dbg.pend, 0);
        @(posedge clk); #1;
        send_frame('{5'd7}, 1'b1, 0);
        wait_results();

        // Back-to-back frames with in_valid kept high.
        k = 0;
        for (int f = 0; f < 3; f++) begin
            xs = {};
            for (int i = 0; i < b2b_len[f]; i++) xs.push_back(L'(b2b_x[k + i]));
            exp_q.push_back(model(xs));
            for (int i = 0; i < b2b_len[f]; i++) begin
                drive_sample(xs[i], i == b2b_len[f] - 1, w);
                check("b2b_in_ready_gap", w, (i == 0 && f > 0) ? 2 : 0);
            end
            k += b2b_len[f];
        end
        wait_results();

        // Randomized frames with input gaps and output back-pressure.
        stall_pct = 30;
        for (int f = 0; f < 25; f++) begin
            xs = {};
            repeat ($urandom_range(20, 1)) begin
                if (f % 5 == 4) xs.push_back(L'($urandom_range(31, 28)));
                else            xs.push_back(L'($urandom_range(31)));
            end
            send_frame(xs, 1'b1, 2);
        end
        wait_results();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
